countdown_timer: RTL and testbench

Loadable down-counter and countdown timer for the Computer16 datapath, complementing the existing up-counting binary counter. It holds a WIDTH-bit count that software or the sequencer loads, decrements one step at a time in manual mode, or decrements autonomously through a programmable prescaler. At terminal count it raises a one-cycle pulse, with optional automatic reload for periodic events such as loop counts, timeouts and timer interrupts.

---
 rtl/countdown_timer_if.sv | 29 ++
 rtl/countdown_timer.sv | 106 ++++++++++
 tb/tb_countdown_timer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer.
// The master drives the load value and controls; the slave returns count and status.
interface countdown_timer_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 8
);
  logic [WIDTH-1:0]      in;
  logic                  load;
  logic                  dec;
  logic                  start;
  logic                  stop;
  logic                  auto_reload;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      out;
  logic                  zero;
  logic                  busy;
  logic                  done;
  logic                  tc_pulse;

  modport master (
    output in, load, dec, start, stop, auto_reload, prescale,
    input  out, zero, busy, done, tc_pulse
  );

  modport slave (
    input  in, load, dec, start, stop, auto_reload, prescale,
    output out, zero, busy, done, tc_pulse
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter / prescaled countdown timer.
// It raises a one-cycle terminal-count strobe and can optionally reload the count automatically.
module countdown_timer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      reload_q, reload_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  done_q, done_d;
  logic                  tc_pulse_q, tc_pulse_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      pre_cnt_q  <= '0;
      done_q     <= 1'b0;
      tc_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      pre_cnt_q  <= pre_cnt_d;
      done_q     <= done_d;
      tc_pulse_q <= tc_pulse_d;
    end
  end

  // Only the highest-priority asserted control acts; an ignored start/dec leaves a run ticking.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    pre_cnt_d  = pre_cnt_q;
    done_d     = done_q;
    tc_pulse_d = 1'b0;

    if (bus.load) begin
      count_d   = bus.in;
      reload_d  = bus.in;
      pre_cnt_d = '0;
      done_d    = 1'b0;
      state_d   = IDLE;
    end else if (bus.stop) begin
      if (state_q == RUN) begin
        state_d   = IDLE;
        pre_cnt_d = '0;
      end
    end else if (bus.start && (state_q != RUN)) begin
      if (count_q != '0) begin
        state_d   = RUN;
        pre_cnt_d = '0;
        done_d    = 1'b0;
      end else if (reload_q != '0) begin
        count_d   = reload_q;
        state_d   = RUN;
        pre_cnt_d = '0;
        done_d    = 1'b0;
      end
    end else if (bus.dec && (state_q != RUN)) begin
      count_d = count_q - WIDTH'(1);
    end else if (state_q == RUN) begin
      if (pre_cnt_q == bus.prescale) begin
        pre_cnt_d = '0;
        if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else if (count_q == WIDTH'(1)) begin
          tc_pulse_d = 1'b1;
          done_d     = 1'b1;
          if (bus.auto_reload) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = DONE;
          end
        end else begin
          // A zero count can only be reached by reloading zero; end the run quietly.
          state_d = DONE;
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
      end
    end
  end

  assign bus.out      = count_q;
  assign bus.zero     = (count_q == '0);
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.tc_pulse = tc_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: inputs change 1 time unit after a rising edge,
// and outputs are checked at the same point.
module tb_countdown_timer;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned PRESCALE_W = 8;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  countdown_timer_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

  countdown_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    bus.in   = v;
    bus.load = 1'b1;
    tick(1);
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.in          = '0;
    bus.load        = 1'b0;
    bus.dec         = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.auto_reload = 1'b0;
    bus.prescale    = '0;
    tick(2);
    chk("rst_out",  32'(bus.out), 32'h0);
    chk("rst_zero", 32'(bus.zero), 32'h1);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_tc",   32'(bus.tc_pulse), 32'h0);
    reset = 1'b0;

    // One-shot from 3, no prescale
    do_load(16'd3);
    chk("os_load", 32'(bus.out), 32'd3);
    do_start();
    chk("os_busy", 32'(bus.busy), 32'h1);
    chk("os_s0", 32'(bus.out), 32'd3);
    tick(1); chk("os_s1", 32'(bus.out), 32'd2);
    tick(1); chk("os_s2", 32'(bus.out), 32'd1);
    chk("os_tc_early", 32'(bus.tc_pulse), 32'h0);
    tick(1);
    chk("os_s3",    32'(bus.out), 32'd0);
    chk("os_tc",    32'(bus.tc_pulse), 32'h1);
    chk("os_done",  32'(bus.done), 32'h1);
    chk("os_idle",  32'(bus.busy), 32'h0);
    chk("os_zero",  32'(bus.zero), 32'h1);
    tick(1);
    chk("os_tc_off", 32'(bus.tc_pulse), 32'h0);
    chk("os_sticky", 32'(bus.done), 32'h1);
    do_start();
    chk("rr_out",  32'(bus.out), 32'd3);
    chk("rr_busy", 32'(bus.busy), 32'h1);
    chk("rr_done", 32'(bus.done), 32'h0);
    tick(3);
    chk("rr_end",  32'(bus.out), 32'd0);
    chk("rr_tc",   32'(bus.tc_pulse), 32'h1);

    // Reset landing on the edge that would be terminal count
    do_load(16'd2);
    do_start();
    tick(1);
    chk("mr_pre", 32'(bus.out), 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mr_out",  32'(bus.out), 32'h0);
    chk("mr_zero", 32'(bus.zero), 32'h1);
    chk("mr_busy", 32'(bus.busy), 32'h0);
    chk("mr_done", 32'(bus.done), 32'h0);
    chk("mr_tc",   32'(bus.tc_pulse), 32'h0);

    // Manual step and wrap
    do_load(16'd1);
    bus.dec = 1'b1;
    tick(1);
    chk("dec_0",    32'(bus.out), 32'h0);
    chk("dec_0_tc", 32'(bus.tc_pulse), 32'h0);
    tick(1);
    bus.dec = 1'b0;
    chk("dec_wrap", 32'(bus.out), 32'hFFFF);
    chk("dec_done", 32'(bus.done), 32'h0);
    chk("dec_tc",   32'(bus.tc_pulse), 32'h0);
    chk("dec_nz",   32'(bus.zero), 32'h0);

    // dec while running is ignored
    bus.prescale = 8'd3;
    do_load(16'd5);
    do_start();
    bus.dec = 1'b1;
    tick(1);
    bus.dec = 1'b0;
    chk("dec_busy", 32'(bus.out), 32'd5);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;

    // Prescaled auto-reload: period 10, out 2 then 1 for five cycles each
    bus.prescale    = 8'd4;
    bus.auto_reload = 1'b1;
    do_load(16'd2);
    do_start();
    for (int p = 0; p < 3; p++) begin
      tick(4);
      chk("ar_hi",    32'(bus.out), 32'd2);
      chk("ar_hi_tc", 32'(bus.tc_pulse), 32'h0);
      tick(1);
      chk("ar_dec",   32'(bus.out), 32'd1);
      tick(4);
      chk("ar_lo",    32'(bus.out), 32'd1);
      chk("ar_lo_tc", 32'(bus.tc_pulse), 32'h0);
      tick(1);
      chk("ar_rel",   32'(bus.out), 32'd2);
      chk("ar_tc",    32'(bus.tc_pulse), 32'h1);
      chk("ar_busy",  32'(bus.busy), 32'h1);
    end
    tick(1);
    chk("ar_tc_off", 32'(bus.tc_pulse), 32'h0);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    bus.auto_reload = 1'b0;

    // Stop and resume
    bus.prescale = 8'd1;
    do_load(16'd10);
    do_start();
    tick(6);
    chk("sr_7", 32'(bus.out), 32'd7);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk("sr_busy", 32'(bus.busy), 32'h0);
    tick(3);
    chk("sr_held", 32'(bus.out), 32'd7);
    do_start();
    chk("sr_rbusy", 32'(bus.busy), 32'h1);
    tick(1);
    chk("sr_wait", 32'(bus.out), 32'd7);
    tick(1);
    chk("sr_next", 32'(bus.out), 32'd6);

    // Collisions
    bus.in    = 16'h1234;
    bus.load  = 1'b1;
    bus.start = 1'b1;
    tick(1);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    chk("ls_out",  32'(bus.out), 32'h1234);
    chk("ls_busy", 32'(bus.busy), 32'h0);
    tick(2);
    chk("ls_stay", 32'(bus.busy), 32'h0);
    do_start();
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    tick(1);
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    chk("ss_busy", 32'(bus.busy), 32'h0);
    chk("ss_out",  32'(bus.out), 32'h1234);
    do_load(16'd0);
    do_start();
    chk("z_busy", 32'(bus.busy), 32'h0);
    chk("z_out",  32'(bus.out), 32'h0);

    // reload 1, auto-reload, no prescale: strobe every cycle
    bus.prescale    = 8'd0;
    bus.auto_reload = 1'b1;
    do_load(16'd1);
    do_start();
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("r1_tc",  32'(bus.tc_pulse), 32'h1);
      chk("r1_out", 32'(bus.out), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
